// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - SPI command decoder driving an 8x8 register file.
// Optional SPI_REGFILE_STATUS_EN turns reg 7 into a read-only committed-write counter.
module spi_regfile #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        ss,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_latch,
    output logic [63:0] regs_flat,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr,
    output logic        cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDWAIT,
        S_DISCARD
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_ss_meta;
    logic        r_ss_s;
    logic        r_ss_d;
    logic        r_rdy_meta;
    logic        r_rdy_s;
    logic        r_rdy_d;

    logic [2:0]  r_addr;
    logic [7:0]  r_regs [0:7];

    logic        w_byte_evt;
    logic        w_ss_rise;
    logic        w_ss_fall;
    logic        w_cmd_ok;
    logic        w_addr_ld;
    logic        w_wr_en;
    logic        w_err;
    logic        w_latch;
    logic [7:0]  w_rd_val;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_meta  <= 1'b0;
            r_ss_s     <= 1'b0;
            r_ss_d     <= 1'b0;
            r_rdy_meta <= 1'b0;
            r_rdy_s    <= 1'b0;
            r_rdy_d    <= 1'b0;
        end else begin
            r_ss_meta  <= ss;
            r_ss_s     <= r_ss_meta;
            r_ss_d     <= r_ss_s;
            r_rdy_meta <= rx_rdy;
            r_rdy_s    <= r_rdy_meta;
            r_rdy_d    <= r_rdy_s;
        end
    end

    assign w_byte_evt = r_rdy_s & ~r_rdy_d;
    assign w_ss_rise  = r_ss_s & ~r_ss_d;
    assign w_ss_fall  = ~r_ss_s & r_ss_d;

`ifdef SPI_REGFILE_STATUS_EN
    logic [7:0] r_wcnt;

    // Reg 7 is read-only here, so a write command aimed at it is illegal.
    assign w_cmd_ok = (rx_data[6:3] == 4'd0) && !(rx_data[7] && (rx_data[2:0] == 3'd7));
    assign w_rd_val = (r_addr == 3'd7) ? r_wcnt : r_regs[r_addr];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= 8'h00;
        end else if (w_wr_en) begin
            r_wcnt <= r_wcnt + 8'd1;
        end
    end
`else
    assign w_cmd_ok = (rx_data[6:3] == 4'd0);
    assign w_rd_val = r_regs[r_addr];
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A synchronised ss falling edge always takes priority over a byte in the same cycle.
    always_comb begin
        w_next    = r_state;
        w_addr_ld = 1'b0;
        w_wr_en   = 1'b0;
        w_err     = 1'b0;
        w_latch   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ss_rise) begin
                    w_next = S_CMD;
                end
            end
            S_CMD: begin
                if (w_ss_fall) begin
                    w_next = S_IDLE;
                end else if (w_byte_evt) begin
                    if (!w_cmd_ok) begin
                        w_err  = 1'b1;
                        w_next = S_DISCARD;
                    end else begin
                        w_addr_ld = 1'b1;
                        w_next    = rx_data[7] ? S_WDATA : S_RDWAIT;
                    end
                end
            end
            S_WDATA: begin
                if (w_ss_fall) begin
                    w_next = S_IDLE;
                end else if (w_byte_evt) begin
                    w_wr_en = 1'b1;
                    w_next  = S_CMD;
                end
            end
            S_RDWAIT: begin
                if (w_ss_fall) begin
                    w_latch = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (w_ss_fall) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= 3'd0;
            tx_data   <= 8'h00;
            tx_latch  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 3'd0;
            cmd_err   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else begin
            tx_latch  <= w_latch;
            wr_strobe <= w_wr_en;
            cmd_err   <= w_err;
            if (w_addr_ld) begin
                r_addr <= rx_data[2:0];
            end
            if (w_wr_en) begin
                r_regs[r_addr] <= rx_data;
                wr_addr        <= r_addr;
            end
            if (w_latch) begin
                tx_data <= w_rd_val;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 7; g++) begin : g_flat
            assign regs_flat[8*g +: 8] = r_regs[g];
        end
    endgenerate

`ifdef SPI_REGFILE_STATUS_EN
    assign regs_flat[63:56] = r_wcnt;
`else
    assign regs_flat[63:56] = r_regs[7];
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// tb/tb_spi_regfile.sv - randomized scoreboard bench for spi_regfile.
module tb_spi_regfile;

    localparam logic [7:0] TB_RST = 8'h3C;
`ifdef SPI_REGFILE_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ss;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic [7:0]  tx_data;
    logic        tx_latch;
    logic [63:0] regs_flat;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic        cmd_err;

    spi_regfile #(.RST_VAL(TB_RST)) dut (
        .sys_clk   (clk),
        .rst_n     (rst_n),
        .ss        (ss),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .tx_data   (tx_data),
        .tx_latch  (tx_latch),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [2:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] fb[$];
    logic [7:0] mreg [0:7];
    logic [7:0] mcnt;
    logic [7:0] mtx;
    logic [2:0] mwa;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, expv);
        end
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] f;
        for (int i = 0; i < 8; i++) f[8*i +: 8] = mreg[i];
        if (STATUS) f[63:56] = mcnt;
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = TB_RST;
        mcnt = 8'h00;
        mtx  = 8'h00;
        mwa  = 3'd0;
        expq.delete();
    endtask

    // Walk the frame's bytes as a command stream; the frame end decides any read.
    task automatic model_frame();
        int         st;
        logic [2:0] a;
        logic [7:0] b;
        exp_t       e;
        st = 1;
        a  = 3'd0;
        foreach (fb[i]) begin
            b = fb[i];
            if (st == 1) begin
                if (b[6:3] != 4'd0 || (STATUS && b[7] && b[2:0] == 3'd7)) begin
                    e.kind = 1; e.a = 3'd0; e.d = 8'h00; expq.push_back(e);
                    st = 4;
                end else begin
                    a  = b[2:0];
                    st = b[7] ? 2 : 3;
                end
            end else if (st == 2) begin
                mreg[a] = b;
                mcnt    = mcnt + 8'd1;
                mwa     = a;
                e.kind = 0; e.a = a; e.d = b; expq.push_back(e);
                st = 1;
            end
        end
        if (st == 3) begin
            mtx = (STATUS && a == 3'd7) ? mcnt : mreg[a];
            e.kind = 2; e.a = a; e.d = mtx; expq.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2 rx_data = b;
        @(posedge clk); #2 rx_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #2 rx_rdy = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic run_frame(input string nm);
        model_frame();
        @(posedge clk); #2 ss = 1'b1;
        repeat (5) @(posedge clk);
        foreach (fb[i]) send_byte(fb[i]);
        repeat (4) @(posedge clk);
        #2 ss = 1'b0;
        repeat (8) @(posedge clk);
        chk({nm, "_drain"}, expq.size(), 0);
        chk({nm, "_regs"}, regs_flat, model_flat());
        chk({nm, "_tx_hold"}, tx_data, mtx);
        expq.delete();
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_tx_data"}, tx_data, 8'h00);
        chk({nm, "_tx_latch"}, tx_latch, 1'b0);
        chk({nm, "_wr_strobe"}, wr_strobe, 1'b0);
        chk({nm, "_wr_addr"}, wr_addr, 3'd0);
        chk({nm, "_cmd_err"}, cmd_err, 1'b0);
        chk({nm, "_regs"}, regs_flat, model_flat());
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    logic       pend = 1'b0;
    int         pa;
    logic [7:0] pd;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (pend) begin
                chk("regs_after_wr", regs_flat[pa*8 +: 8], pd);
                pend = 1'b0;
            end
            if (wr_strobe) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_wr_strobe actual=1 expected=0 addr=%0d", wr_addr);
                end else begin
                    e = expq.pop_front();
                    chk("event_is_write", e.kind, 0);
                    chk("wr_addr", wr_addr, e.a);
                    pend = 1'b1; pa = e.a; pd = e.d;
                end
            end
            if (cmd_err) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_cmd_err actual=1 expected=0");
                end else begin
                    e = expq.pop_front();
                    chk("event_is_err", e.kind, 1);
                end
            end
            if (tx_latch) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_tx_latch actual=1 expected=0 data=%h", tx_data);
                end else begin
                    e = expq.pop_front();
                    chk("event_is_latch", e.kind, 2);
                    chk("tx_data_latched", tx_data, e.d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        int         n;
        rst_n = 1'b0; ss = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        fb = '{8'h83, 8'h5A};        run_frame("write_r3");
        fb = '{8'h03};               run_frame("read_r3");
        fb = '{8'h48, 8'h81, 8'hFF}; run_frame("illegal_cmd");
        fb = '{8'h81};               run_frame("abandoned_write");
        fb = '{8'h85, 8'hC3, 8'h05, 8'h77}; run_frame("write_read_r5");
        fb = '{8'h87, 8'h99, 8'h07}; run_frame("reg7_access");

        // Reset arriving while a data byte is still in the synchronisers.
        fb = '{8'h82};
        @(posedge clk); #2 ss = 1'b1;
        repeat (5) @(posedge clk);
        send_byte(8'h82);
        @(posedge clk); #2 rx_data = 8'h55; rx_rdy = 1'b1;
        @(posedge clk); #3 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("midframe_reset");
        ss = 1'b0; rx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        chk("post_reset_regs", regs_flat, model_flat());
        fb = '{8'h82, 8'h11};        run_frame("write_after_reset");

        for (int f = 0; f < 40; f++) begin
            fb.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                r = 8'($urandom);
                if ($urandom_range(0, 7) != 0) r[6:3] = 4'd0;
                fb.push_back(r);
            end
            run_frame("random");
        end
        chk("final_wr_addr", wr_addr, mwa);

`ifdef SPI_REGFILE_STATUS_EN
        @(posedge clk); #3 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("status_reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        fb.delete();
        for (int i = 0; i < 256; i++) begin
            fb.push_back(8'h80 | 8'($urandom_range(0, 6)));
            fb.push_back(8'($urandom));
        end
        run_frame("status_256_writes");
        fb = '{8'h07};               run_frame("status_read_wrap");
        chk("status_count_zero", tx_data, 8'h00);
        fb = '{8'h87, 8'h12};        run_frame("status_write_rejected");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 SHALL have parameter RST_VAL, default 8'h00: reset value of every read/write register.
REQ-002 SHALL have port sys_clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ss  in  1  SPI frame select, active-high, asynchronous to sys_clk.
REQ-005 SHALL have port rx_data  in  8  received byte from the SPI slave, stable while rx_rdy high.
REQ-006 SHALL have port rx_rdy  in  1  slave byte-ready level, asynchronous to sys_clk.
REQ-007 SHALL have port tx_data  out  8  byte presented to the slave for its next frame.
REQ-008 SHALL have port tx_latch  out  1  one-cycle load pulse to the slave.
REQ-009 SHALL have port regs_flat  out  64  register file contents, reg N at bits [8N+7:8N].
REQ-010 SHALL have port wr_strobe  out  1  one-cycle pulse per committed write.
REQ-011 SHALL have port wr_addr  out  3  address of the last committed write.
REQ-012 SHALL have port cmd_err  out  1  one-cycle pulse on an illegal command.

Function
REQ-013 SHALL pass ss and rx_rdy through two-flop synchronisers (ss_s, rdy_s).
REQ-014 SHALL generate byte_evt for one cycle on each rdy_s rising edge; rx_data sampled in that cycle.
REQ-015 SHALL use states IDLE, CMD, WDATA, RDWAIT, DISCARD.
REQ-016 IDLE: ss_s rising edge -> CMD; byte_evt ignored.
REQ-017 CMD, byte_evt: byte[7]=1 and byte[6:3]=0 -> latch addr=byte[2:0], -> WDATA.
REQ-018 CMD, byte_evt: byte[7]=0 and byte[6:3]=0 -> latch addr, -> RDWAIT.
REQ-019 CMD, byte_evt: byte[6:3]!=0 -> cmd_err pulse, -> DISCARD.
REQ-020 WDATA, byte_evt: reg[addr]<=rx_data, wr_strobe=1, wr_addr=addr, all in the same cycle; -> CMD; multiple commands per frame allowed.
REQ-021 RDWAIT: on ss_s falling edge -> tx_data<=reg[addr], tx_latch=1 for exactly one cycle, -> IDLE; further byte_evt ignored.
REQ-022 DISCARD: all byte_evt ignored until ss_s falling edge -> IDLE.
REQ-023 CMD, WDATA, or DISCARD: ss_s falling edge -> IDLE; pending write abandoned, no strobe.
REQ-024 byte_evt coincident with ss_s falling edge: edge wins, byte discarded (RDWAIT still latches).
REQ-025 Latency: write commits 3 sys_clk cycles after rx_rdy rises (2 sync + 1 edge detect).
REQ-026 tx_data SHALL hold its value between tx_latch pulses.
REQ-027 regs_flat SHALL reflect writes in the cycle after wr_strobe.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, all registers to RST_VAL, tx_data=8'h00, tx_latch=0, wr_strobe=0, wr_addr=0, cmd_err=0, synchronisers to 0.
REQ-029 Reset mid-frame SHALL discard partial commands; after release, CMD is entered only on a fresh ss_s rising edge.

Configuration
REQ-030 With SPI_REGFILE_STATUS_EN defined, reg 7 SHALL be a read-only 8-bit count of committed writes, reset 0, wrapping 255->0; a write command to addr 7 pulses cmd_err and -> DISCARD.
REQ-031 Without SPI_REGFILE_STATUS_EN, reg 7 SHALL be an ordinary read/write register identical to regs 0-6.

Verification
REQ-032 Frame with bytes 0x83, 0x5A -> wr_strobe once, wr_addr=3, regs_flat[31:24]=0x5A, others RST_VAL.
REQ-033 Frame with byte 0x03 after reg3=0x5A, then ss low -> single tx_latch pulse, tx_data=0x5A.
REQ-034 Frame with byte 0x48, 0x81, 0xFF -> cmd_err once, no wr_strobe, regs unchanged.
REQ-035 Frame 0x81 only, ss low before the data byte -> no wr_strobe, reg1 unchanged, state IDLE.
REQ-036 rst_n low after 0x82 received, mid data byte -> all outputs at reset values at once; next frame 0x82, 0x11 writes reg2=0x11.
REQ-037 With SPI_REGFILE_STATUS_EN: 256 writes then read addr 7 -> tx_data=0x00; write to 0x87 -> cmd_err, reg7 unchanged.
